// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant and select generator for a 4:1 data mux,
// with release, requester-drop and hold-limit grant termination.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] req_i,
    input  logic       rel_i,
    output logic [3:0] gnt_o,
    output logic [1:0] s_o,
    output logic       busy_o,
    output logic       timeout_o
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD - 1);
    state_e     state_q;
    logic [3:0] gnt_q, hold_q, hold_d;
    logic [1:0] s_q, last_q, winner;
    logic       busy_q, timeout_q, any_req, hold_max, exit_grant, expired_only;
    // Descending scan so the requester closest after last_q is assigned last and wins.
    always_comb begin
        winner = last_q;
        for (int k = 4; k >= 1; k--)
            if (req_i[last_q + 2'(k)]) winner = last_q + 2'(k);
    end
    assign any_req      = |req_i;
    assign hold_max     = hold_q == HOLD_MAX;
    assign hold_d       = hold_max ? hold_q : hold_q + 4'd1;
    assign exit_grant   = rel_i || !req_i[last_q] || hold_max;
    assign expired_only = !rel_i && req_i[last_q] && hold_max;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            s_q       <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= 2'd3;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                GRANT: begin
                    if (exit_grant) begin
                        state_q   <= GAP;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        timeout_q <= expired_only;
                    end else begin
                        hold_q <= hold_d;
                    end
                end
                default: begin
                    if (any_req) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'b0001 << winner;
                        s_q     <= winner;
                        last_q  <= winner;
                        hold_q  <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
    assign gnt_o     = gnt_q;
    assign s_o       = s_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scenarios with hand-computed {gnt, s, busy, timeout} expectations.
module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       rel = 1'b0;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       busy, timeout;
    logic [7:0] obs;
    int vectors = 0;
    int miscompares = 0;

    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .rel_i(rel),
        .gnt_o(gnt), .s_o(s), .busy_o(busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;
    assign obs = {gnt, s, busy, timeout};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        rel = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b0001;
        #2;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async got %b want %b", obs, 8'h00);
        end
        step();
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_held got %b want %b", obs, 8'h00);
        end
        req = '0;
        #2;
        rst_n = 1'b1;
        step();
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_idle got %b want %b", obs, 8'h00);
        end
    endtask

    task automatic test_basic();
        req = 4'b0001;
        step();
        vectors++;
        if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_grant got %b want %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
        rel = 1'b1;
        step();
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL basic_gap got %b want %b", obs, 8'h00);
        end
        rel = 1'b0;
        step();
        vectors++;
        if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_regrant got %b want %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
        req = '0;
        step();
        step();
        rel = 1'b1;
        step();
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL basic_rel_idle_ignored got %b want %b", obs, 8'h00);
        end
        rel = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp;
        do_reset();
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            exp = {4'b0001 << order[i], order[i], 1'b1, 1'b0};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rr_grant[%0d] got %b want %b", i, obs, exp);
            end
            rel = 1'b1;
            step();
            exp = {4'b0000, order[i], 1'b0, 1'b0};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rr_gap[%0d] got %b want %b", i, obs, exp);
            end
            rel = 1'b0;
            step();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0100;
        step();
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL hold_cycle[%0d] got %b want %b", c, obs, {4'b0100, 2'd2, 1'b1, 1'b0});
            end
            step();
        end
        vectors++;
        if (obs !== {4'b0000, 2'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_gap got %b want %b", obs, {4'b0000, 2'd2, 1'b0, 1'b1});
        end
        step();
        vectors++;
        if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_regrant got %b want %b", obs, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
    endtask

    task automatic test_priority();
        do_reset();
        req = 4'b0010;
        step();
        vectors++;
        if (obs !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_first got %b want %b", obs, {4'b0010, 2'd1, 1'b1, 1'b0});
        end
        req = 4'b1010;
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        vectors++;
        if (obs !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_after1 got %b want %b", obs, {4'b1000, 2'd3, 1'b1, 1'b0});
        end
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        vectors++;
        if (obs !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_wrap got %b want %b", obs, {4'b0010, 2'd1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        step();
        vectors++;
        if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL areset_pre got %b want %b", obs, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL areset_drop got %b want %b", obs, 8'h00);
        end
        #2;
        rst_n = 1'b1;
        step();
        vectors++;
        if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL areset_first_arb got %b want %b", obs, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b0001;
        step();
        vectors++;
        if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL drop_grant0 got %b want %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
        req = 4'b1000;
        step();
        vectors++;
        if (obs !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL drop_gap got %b want %b", obs, {4'b0000, 2'd0, 1'b0, 1'b0});
        end
        step();
        vectors++;
        if (obs !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL drop_grant3 got %b want %b", obs, {4'b1000, 2'd3, 1'b1, 1'b0});
        end
        for (int c = 0; c < 6; c++) begin
            req = 4'(c * 5 + 3);
            step();
            vectors++;
            if (!$onehot0(gnt)) begin
                miscompares++;
                $display("FAIL onehot[%0d] got %b want at most one bit", c, gnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_priority();
        test_async_reset();
        test_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive cycles one requester may hold the grant (legal 1..15).
REQ-002 CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 REQ  input  4  request vector; REQ[i] = requester i wants Mux4to1 data input Di.
REQ-005 REL  input  1  release strobe from the current holder; sampled only in GRANT.
REQ-006 GNT  output  4  one-hot grant, or all-zero; registered.
REQ-007 S  output  2  Mux4to1 select; equals the granted index while GNT is non-zero; registered.
REQ-008 BUSY  output  1  high while in GRANT state.
REQ-009 TIMEOUT  output  1  one-cycle pulse when a grant ends by MAX_HOLD expiry.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT and GAP.
REQ-011 Internal LAST pointer (2 bits) SHALL hold the index of the most recent grant.
REQ-012 Arbitration SHALL be round-robin: search REQ starting at (LAST+1) mod 4, wrapping past 3 to 0; the first set bit wins.
REQ-013 In IDLE or GAP, if any REQ bit is set at a rising edge, the next state SHALL be GRANT, with GNT = onehot(winner), S = winner, LAST = winner and hold counter = 0, all registered on that edge.
REQ-014 In IDLE or GAP with REQ = 0000, the next state SHALL be IDLE.
REQ-015 GAP SHALL last exactly one cycle, with GNT = 0000 and BUSY = 0.
REQ-016 Grant latency SHALL be one cycle: REQ sampled at edge k produces GNT valid after edge k.
REQ-017 In GRANT, the hold counter SHALL increment by 1 per cycle, saturating at MAX_HOLD-1; the counter is 4 bits wide.
REQ-018 GRANT SHALL exit to GAP on the first edge where any of these holds: REL = 1; REQ[LAST] = 0; hold counter = MAX_HOLD-1.
REQ-019 TIMEOUT SHALL be asserted for the single cycle following an exit caused only by counter expiry (REL = 0 and REQ[LAST] = 1 at that edge).
REQ-020 Grant duration SHALL never exceed MAX_HOLD cycles; with MAX_HOLD = 1, every grant lasts exactly one cycle and raises TIMEOUT if REL = 0.
REQ-021 GNT SHALL be all-zero in IDLE and GAP.
REQ-022 S SHALL keep its last granted value in IDLE and GAP, so the mux never switches mid-grant.
REQ-023 GNT SHALL never have more than one bit set.
REQ-024 REL outside GRANT SHALL be ignored.
REQ-025 REQ changes during GRANT SHALL not alter GNT or S, except through REQ[LAST] per REQ-018.
REQ-026 A requester re-asserting in GAP SHALL compete normally; a sole requester SHALL be re-granted after the one-cycle GAP.

Reset
REQ-027 RST_N = 0 SHALL immediately, without waiting for CLK, force:
- state = IDLE
- GNT = 0000, S = 00
- BUSY = 0, TIMEOUT = 0
- hold counter = 0
- LAST = 3, so requester 0 has first priority.
REQ-028 Reset asserted mid-GRANT SHALL drop GNT asynchronously.
REQ-029 After RST_N deasserts, the first arbitration SHALL occur on the first rising edge at which RST_N is high.

Verification
REQ-030 Reset release, REQ=0001 -> next cycle GNT=0001, S=00, BUSY=1; REL pulse -> GNT=0000 (GAP) one cycle -> GNT=0001 again while REQ=0001.
REQ-031 REQ=1111 held, REL pulsed one cycle after each grant -> grant order 0,1,2,3,0 with one GAP cycle between grants; S follows 00,01,10,11,00.
REQ-032 MAX_HOLD=8, REQ=0100 held, REL=0 -> GNT=0100 for exactly 8 cycles, TIMEOUT=1 for one cycle, then GAP, then GNT=0100 re-granted.
REQ-033 After a grant to 1 (LAST=1), REQ=1010 -> GNT=1000, S=11; on release -> GNT=0010, S=01.
REQ-034 RST_N driven low between clock edges during GRANT of requester 2 -> GNT=0000, S=00, BUSY=0 immediately; after release with REQ=0100 -> GNT=0100.
REQ-035 During GRANT of 0, drop REQ[0] with REQ[3] set -> GAP next cycle with TIMEOUT=0, then GNT=1000; GNT stays one-hot or zero throughout.
